// File: rtl/fft2d_ctrl.sv
// Sequencer for an in-place 32x32 2-D FFT: 32 row transforms then 32 column transforms.
// Optional FFT2D_CTRL_ABORT_EN adds an abort input that returns to idle without done.
module fft2d_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
`ifdef FFT2D_CTRL_ABORT_EN
    input  logic       abort,
`endif
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] line,
    output logic       mem_rd,
    output logic [9:0] mem_raddr,
    output logic       mem_wr,
    output logic [9:0] mem_waddr,
    output logic       fft_load,
    output logic       fft_start,
    input  logic       fft_done,
    output logic       fft_unload
);

    typedef enum logic [2:0] {StIdle, StLoad, StKick, StWait, StStore, StDone} state_t;

    state_t     state;
    logic [4:0] k;
    logic [9:0] unload_addr;
    logic       abort_hit;

`ifdef FFT2D_CTRL_ABORT_EN
    assign abort_hit = abort && (state != StIdle);
`else
    assign abort_hit = 1'b0;
`endif

    // Row pass walks along a row; column pass swaps the fields so MSBs stay the row.
    function automatic logic [9:0] addr_of(input logic p, input logic [4:0] l,
                                           input logic [4:0] kk);
        return p ? {kk, l} : {l, kk};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            pass        <= 1'b0;
            line        <= 5'd0;
            k           <= 5'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_rd      <= 1'b0;
            mem_raddr   <= 10'd0;
            mem_wr      <= 1'b0;
            mem_waddr   <= 10'd0;
            fft_load    <= 1'b0;
            fft_start   <= 1'b0;
            fft_unload  <= 1'b0;
            unload_addr <= 10'd0;
        end else if (abort_hit) begin
            // Squash everything in flight, including the delayed write and load.
            state       <= StIdle;
            pass        <= 1'b0;
            line        <= 5'd0;
            k           <= 5'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_rd      <= 1'b0;
            mem_raddr   <= 10'd0;
            mem_wr      <= 1'b0;
            mem_waddr   <= 10'd0;
            fft_load    <= 1'b0;
            fft_start   <= 1'b0;
            fft_unload  <= 1'b0;
            unload_addr <= 10'd0;
        end else begin
            fft_load  <= mem_rd;
            mem_wr    <= fft_unload;
            mem_waddr <= unload_addr;
            done      <= 1'b0;
            fft_start <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state     <= StLoad;
                        pass      <= 1'b0;
                        line      <= 5'd0;
                        k         <= 5'd0;
                        busy      <= 1'b1;
                        mem_rd    <= 1'b1;
                        mem_raddr <= 10'd0;
                    end
                end
                StLoad: begin
                    if (k == 5'd31) begin
                        state     <= StKick;
                        k         <= 5'd0;
                        mem_rd    <= 1'b0;
                        fft_start <= 1'b1;
                    end else begin
                        k         <= k + 5'd1;
                        mem_raddr <= addr_of(pass, line, k + 5'd1);
                    end
                end
                StKick: state <= StWait;
                StWait: begin
                    if (fft_done) begin
                        state       <= StStore;
                        k           <= 5'd0;
                        fft_unload  <= 1'b1;
                        unload_addr <= addr_of(pass, line, 5'd0);
                    end
                end
                StStore: begin
                    if (k == 5'd31) begin
                        k          <= 5'd0;
                        fft_unload <= 1'b0;
                        if (line != 5'd31) begin
                            state     <= StLoad;
                            line      <= line + 5'd1;
                            mem_rd    <= 1'b1;
                            mem_raddr <= addr_of(pass, line + 5'd1, 5'd0);
                        end else if (!pass) begin
                            state     <= StLoad;
                            pass      <= 1'b1;
                            line      <= 5'd0;
                            mem_rd    <= 1'b1;
                            mem_raddr <= addr_of(1'b1, 5'd0, 5'd0);
                        end else begin
                            state <= StDone;
                            done  <= 1'b1;
                        end
                    end else begin
                        k           <= k + 5'd1;
                        unload_addr <= addr_of(pass, line, k + 5'd1);
                    end
                end
                StDone: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fft2d_ctrl.sv
// Self-checking bench for fft2d_ctrl: directed frames with randomized core latency.
// Define FFT2D_CTRL_ABORT_EN to also exercise the abort input.
module tb_fft2d_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       fft_done = 1'b0;
    logic       abort = 1'b0;
    logic       busy, done, pass, mem_rd, mem_wr, fft_load, fft_start, fft_unload;
    logic [4:0] line;
    logic [9:0] mem_raddr, mem_waddr;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    fft2d_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef FFT2D_CTRL_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .line      (line),
        .mem_rd    (mem_rd),
        .mem_raddr (mem_raddr),
        .mem_wr    (mem_wr),
        .mem_waddr (mem_waddr),
        .fft_load  (fft_load),
        .fft_start (fft_start),
        .fft_done  (fft_done),
        .fft_unload(fft_unload)
    );

    // Reference: n-th access of a frame goes to line n/32 (rows first, then columns), element n%32.
    function automatic int exp_addr(input int n);
        int ln, kk, p, l;
        ln = n / 32;
        kk = n % 32;
        p  = (ln / 32) % 2;
        l  = ln % 32;
        return p ? kk * 32 + l : l * 32 + kk;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // 1-D core model: fft_done on the W-th cycle after the fft_start pulse.
    int w_tab[64];
    int ln_idx = 0;
    int cnt = 0;
    bit spur_en = 0;
    always @(negedge clk) begin
        fft_done = 1'b0;
        if (rst) begin
            cnt    = 0;
            ln_idx = 0;
        end else if (fft_start) begin
            cnt = w_tab[ln_idx % 64];
            ln_idx++;
        end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) fft_done = 1'b1;
        end else if (spur_en && mem_rd && $urandom_range(0, 3) == 0) begin
            fft_done = 1'b1;
        end
    end

    // Observers feeding the scoreboard counters.
    int   rd_n, wr_n, rd_bad, wr_bad, load_bad, starts, done_hi, done_at;
    int   rd_log[2048];
    logic prev_rd = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_rd = 1'b0;
        end else begin
            if (mem_rd) begin
                if (rd_n < 2048) rd_log[rd_n] = int'(mem_raddr);
                if (mem_raddr !== 10'(exp_addr(rd_n))) rd_bad++;
                rd_n++;
            end
            if (mem_wr) begin
                if (mem_waddr !== 10'(exp_addr(wr_n))) wr_bad++;
                wr_n++;
            end
            if (fft_load !== prev_rd) load_bad++;
            prev_rd = mem_rd;
            if (fft_start) starts++;
            if (done) begin
                done_hi++;
                if (done_at < 0) done_at = cyc;
            end
        end
    end

    task automatic clear_mon();
        @(posedge clk);
        #1;
        rd_n = 0; wr_n = 0; rd_bad = 0; wr_bad = 0; load_bad = 0;
        starts = 0; done_hi = 0; done_at = -1;
    endtask

    task automatic do_frame(input string tag, input bit noisy_start);
        int exp_len, t0;
        exp_len = 0;
        for (int i = 0; i < 64; i++) exp_len += 65 + w_tab[i];
        clear_mon();
        @(negedge clk);
        start = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " first_pass"}, 64'(pass), 64'd0);
        chk({tag, " first_line"}, 64'(line), 64'd0);
        chk({tag, " first_raddr"}, 64'(mem_raddr), 64'd0);
        for (int c = 0; c < exp_len + 200 && done_at < 0; c++) begin
            @(negedge clk);
            start = noisy_start && busy && !done && ($urandom_range(0, 15) == 0);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk({tag, " done_edges"}, 64'(done_at - t0), 64'(exp_len));
        chk({tag, " reads"}, 64'(rd_n), 64'd2048);
        chk({tag, " writes"}, 64'(wr_n), 64'd2048);
        chk({tag, " raddr_errs"}, 64'(rd_bad), 64'd0);
        chk({tag, " waddr_errs"}, 64'(wr_bad), 64'd0);
        chk({tag, " load_errs"}, 64'(load_bad), 64'd0);
        chk({tag, " fft_starts"}, 64'(starts), 64'd64);
        chk({tag, " done_width"}, 64'(done_hi), 64'd1);
        chk({tag, " idle_busy"}, 64'(busy), 64'd0);
    endtask

    function automatic logic [63:0] out_vec();
        return 64'({busy, done, mem_rd, mem_wr, mem_raddr, mem_waddr, fft_load, fft_start,
                    fft_unload, pass, line});
    endfunction

    initial begin
        int saved_wr, waited;
        for (int i = 0; i < 64; i++) w_tab[i] = 1;
        #1;
        chk("reset outputs", out_vec(), 64'd0);
        #11;
        rst = 1'b0;

        // W=1 everywhere: 64*66 edges, plus explicit row 3 / column 3 addresses.
        do_frame("w1", 1'b0);
        chk("row3 first", 64'(rd_log[96]), 64'd96);
        chk("row3 last", 64'(rd_log[127]), 64'd127);
        chk("col3 first", 64'(rd_log[1024 + 96]), 64'd3);
        chk("col3 second", 64'(rd_log[1024 + 97]), 64'd35);
        chk("col3 last", 64'(rd_log[1024 + 127]), 64'd995);

        for (int i = 0; i < 64; i++) w_tab[i] = 11;
        do_frame("w11", 1'b0);

        // Random latency, stray start pulses while busy and stray fft_done during LOAD.
        for (int i = 0; i < 64; i++) w_tab[i] = $urandom_range(1, 6);
        spur_en = 1'b1;
        do_frame("noisy", 1'b1);
        spur_en = 1'b0;

        // Reset during STORE of row line 5.
        for (int i = 0; i < 64; i++) w_tab[i] = $urandom_range(1, 4);
        clear_mon();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (!(fft_unload && !pass && line == 5'd5) && waited < 30000) begin
            @(negedge clk);
            waited++;
        end
        chk("reach row5 store", 64'(waited < 30000), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("midframe reset outputs", out_vec(), 64'd0);
        saved_wr = wr_n;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("no write after reset", 64'(wr_n), 64'(saved_wr));
        chk("no done after reset", 64'(done_hi), 64'd0);

        for (int i = 0; i < 64; i++) w_tab[i] = 1;
        do_frame("restart", 1'b0);

`ifdef FFT2D_CTRL_ABORT_EN
        // Abort in WAIT of column line 7.
        for (int i = 0; i < 64; i++) w_tab[i] = 20;
        clear_mon();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (!(fft_start && pass && line == 5'd7) && waited < 30000) begin
            @(negedge clk);
            waited++;
        end
        chk("reach col7 kick", 64'(waited < 30000), 64'd1);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort outputs", out_vec(), 64'd0);
        @(negedge clk);
        abort = 1'b0;
        saved_wr = wr_n;
        repeat (10) @(negedge clk);
        chk("abort no write", 64'(wr_n), 64'(saved_wr));
        chk("abort no done", 64'(done_hi), 64'd0);
        chk("abort stays idle", 64'(busy), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fft2d_ctrl.md
FFT2D_CTRL -- requirements
Module: fft2d_ctrl

Interface
REQ-001 SHALL have ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin one 32x32 frame transform; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, frame complete
- pass  out  1  0 = row pass, 1 = column pass
- line  out  5  current row/column index
- mem_rd  out  1  frame-buffer read strobe; data valid next cycle
- mem_raddr  out  10  read address
- mem_wr  out  1  frame-buffer write strobe
- mem_waddr  out  10  write address, aligned with mem_wr
- fft_load  out  1  1-D core input sample valid
- fft_start  out  1  one-cycle pulse, core begins transform
- fft_done  in  1  core result ready
- fft_unload  out  1  request one core output sample; sample valid next cycle

Function
REQ-002 SHALL sequence 32 row FFTs (pass=0, line 0..31), then 32 column FFTs (pass=1, line 0..31), in place on a dual-port 32x32 buffer.
REQ-003 SHALL implement states IDLE, LOAD, KICK, WAIT, STORE, DONE.
REQ-004 IDLE->LOAD on start=1; pass=0, line=0, k=0.
REQ-005 LOAD: mem_rd=1 for 32 cycles, k=0..31; after k=31 -> KICK.
REQ-006 KICK: fft_start=1 for exactly one cycle -> WAIT.
REQ-007 WAIT: hold until fft_done=1 is sampled, then -> STORE; fft_done outside WAIT SHALL be ignored.
REQ-008 STORE: fft_unload=1 for 32 cycles, k=0..31.
- After k=31 with line<31: line+1 -> LOAD.
- After k=31 with line=31, pass=0: pass=1, line=0 -> LOAD.
- After k=31 with line=31, pass=1: -> DONE.
REQ-009 DONE: done=1 for one cycle -> IDLE.
REQ-010 Address: pass=0 addr={line,k}; pass=1 addr={k,line} (MSBs = row).
REQ-011 fft_load SHALL be mem_rd delayed one cycle.
REQ-012 mem_wr and mem_waddr SHALL be fft_unload and its address delayed one cycle; the final write of a line overlaps the next LOAD or DONE cycle.
REQ-013 start while busy=1 SHALL be ignored.
REQ-014 Each line SHALL take 65+W cycles, W = WAIT cycles (W>=1); frame = 64*(65+W) cycles, start edge to done rise.
REQ-015 k and line SHALL count 0..31 only; no wrap beyond 31 occurs.

Reset
REQ-016 rst=1 SHALL immediately force IDLE, with pass=0, line=0, k=0 and all outputs 0 (busy, done, mem_rd, mem_wr, mem_raddr, mem_waddr, fft_load, fft_start, fft_unload).
REQ-017 Reset mid-frame SHALL drop the pending delayed write: no mem_wr after rst is asserted, and no done.

Configuration
REQ-018 Macro FFT2D_CTRL_ABORT_EN defined: adds input port abort (1 bit).
- abort=1 in any non-IDLE state -> IDLE at the next edge.
- No done pulse; pending delayed mem_wr/fft_load squashed.
- abort in IDLE has no effect; abort has priority over start.
REQ-019 Macro undefined: no abort port; behaviour exactly as REQ-002..017.

Verification
REQ-020 Directed scenarios:
- Full frame, fft_done high on the first WAIT cycle (W=1): done rises exactly 4224 edges after the start edge; exactly 2048 reads and 2048 writes; done=1 for one cycle.
- Address check: pass=0, line=3 reads 96..127 in order; pass=1, line=3 reads 3,35,...,995.
- fft_done delayed 10 cycles every line (W=11): frame takes 64*76 = 4864 cycles; fft_start pulses exactly 64 times.
- start pulsed during busy and fft_done pulsed in LOAD: both ignored, timing unchanged.
- rst asserted in STORE of row line 5: all outputs 0 immediately; no further mem_wr; a new start restarts at pass=0, line=0.
- With FFT2D_CTRL_ABORT_EN: abort in WAIT of column line 7 -> IDLE next edge, busy=0, no done, no write.
